// File: rtl/alu_scan_pkg.sv
// alu_scan_pkg: opcode constants, scan FSM states and default vector geometry for the ALU mutation scanner
package alu_scan_pkg;
    localparam int SCAN_WIDTH = 4;
    localparam int SCAN_OPW   = 3;
    localparam int VEC_W      = 2*SCAN_WIDTH + SCAN_OPW;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/alu_scan_vecgen.sv
// alu_scan_vecgen: {opcode,A,B} vector register stepping B inner, A middle, enabled opcodes outer
module alu_scan_vecgen
    import alu_scan_pkg::*;
#(
    parameter int WIDTH = SCAN_WIDTH,
    parameter int OPW   = SCAN_OPW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              adv,
    input  logic [2**OPW-1:0] mask_in,
    output logic [OPW-1:0]    opcode,
    output logic [WIDTH-1:0]  a,
    output logic [WIDTH-1:0]  b,
    output logic              last
);
    localparam int NOP = 2**OPW;
    logic [NOP-1:0]     mask_q, mask_d;
    logic [OPW-1:0]     op_q, op_d, first_op, nxt_op;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [2*WIDTH-1:0] ab_inc;
    logic               nxt_vld, wrap;
    // descending loop leaves the lowest qualifying index as the final winner
    always_comb begin
        first_op = '0;
        nxt_op   = '0;
        nxt_vld  = 1'b0;
        for (int i = NOP-1; i >= 0; i--) begin
            if (mask_in[i]) first_op = OPW'(i);
            if (mask_q[i] && i > int'(op_q)) begin
                nxt_op  = OPW'(i);
                nxt_vld = 1'b1;
            end
        end
    end
    always_comb begin
        wrap       = &{a_q, b_q};
        last       = wrap & ~nxt_vld;
        ab_inc     = {a_q, b_q} + (2*WIDTH)'(1);
        mask_d     = load ? mask_in : mask_q;
        op_d       = load ? first_op : (adv && wrap) ? nxt_op : op_q;
        {a_d, b_d} = load ? '0 : adv ? ab_inc : {a_q, b_q};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
        end else begin
            mask_q <= mask_d;
            op_q   <= op_d;
            a_q    <= a_d;
            b_q    <= b_d;
        end
    end
    assign opcode = op_q;
    assign a      = a_q;
    assign b      = b_q;
endmodule

// File: rtl/alu_mutation_scan_ctrl.sv
// alu_mutation_scan_ctrl: sweeps all enabled vectors through golden and mutant ALUs and records mismatches
module alu_mutation_scan_ctrl
    import alu_scan_pkg::*;
#(
    parameter int WIDTH        = SCAN_WIDTH,
    parameter int OPW          = SCAN_OPW,
    parameter bit COMPARE_ZERO = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     stop_on_fail,
    input  logic [2**OPW-1:0]        op_mask,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic [OPW-1:0]           alu_opcode,
    input  logic [WIDTH-1:0]         gold_result,
    input  logic                     gold_zero,
    input  logic [WIDTH-1:0]         mut_result,
    input  logic                     mut_zero,
    output logic                     busy,
    output logic                     done,
    output logic [2*WIDTH+OPW:0]     mismatch_cnt,
    output logic [2*WIDTH+OPW:0]     vec_cnt,
    output logic [2**OPW-1:0]        op_fail_map,
    output logic                     first_fail_vld,
    output logic [2*WIDTH+OPW-1:0]   first_fail_vec
);
    localparam int CW  = 2*WIDTH + OPW + 1;
    localparam int VW  = 2*WIDTH + OPW;
    localparam int NOP = 2**OPW;
    state_t          state_q, state_d;
    logic            stop_q, stop_d;
    logic [CW-1:0]   vec_cnt_q, vec_cnt_d, mismatch_cnt_q, mismatch_cnt_d;
    logic [NOP-1:0]  op_fail_map_q, op_fail_map_d;
    logic            first_fail_vld_q, first_fail_vld_d;
    logic [VW-1:0]   first_fail_vec_q, first_fail_vec_d;
    logic            load, adv, last, fail, finish, cmp, hit;
    alu_scan_vecgen #(.WIDTH(WIDTH), .OPW(OPW)) u_vecgen (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .adv     (adv),
        .mask_in (op_mask),
        .opcode  (alu_opcode),
        .a       (alu_a),
        .b       (alu_b),
        .last    (last)
    );
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end
    // abort suppresses counting of the vector on the bus; stop/last still count it
    always_comb begin
        load    = start && state_q != RUN;
        fail    = (gold_result != mut_result) | (COMPARE_ZERO && gold_zero != mut_zero);
        finish  = abort | last | (stop_q & fail);
        state_d = load ? ((|op_mask) ? RUN : DONE) : (state_q == RUN && finish) ? DONE : state_q;
        adv     = state_q == RUN && !finish;
        cmp     = state_q == RUN && !abort;
        hit     = cmp && fail;
    end
    always_comb begin
        busy = state_q == RUN;
        done = state_q == DONE;
    end
    always_comb begin
        stop_d           = load ? stop_on_fail : stop_q;
        vec_cnt_d        = load ? '0 : cmp ? vec_cnt_q + CW'(1) : vec_cnt_q;
        mismatch_cnt_d   = load ? '0 : hit ? mismatch_cnt_q + CW'(1) : mismatch_cnt_q;
        op_fail_map_d    = load ? '0 : hit ? op_fail_map_q | (NOP'(1) << alu_opcode) : op_fail_map_q;
        first_fail_vld_d = load ? 1'b0 : first_fail_vld_q | hit;
        first_fail_vec_d = load ? '0 : (hit && !first_fail_vld_q) ? {alu_opcode, alu_a, alu_b} : first_fail_vec_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            stop_q           <= 1'b0;
            vec_cnt_q        <= '0;
            mismatch_cnt_q   <= '0;
            op_fail_map_q    <= '0;
            first_fail_vld_q <= 1'b0;
            first_fail_vec_q <= '0;
        end else begin
            stop_q           <= stop_d;
            vec_cnt_q        <= vec_cnt_d;
            mismatch_cnt_q   <= mismatch_cnt_d;
            op_fail_map_q    <= op_fail_map_d;
            first_fail_vld_q <= first_fail_vld_d;
            first_fail_vec_q <= first_fail_vec_d;
        end
    end
    assign vec_cnt        = vec_cnt_q;
    assign mismatch_cnt   = mismatch_cnt_q;
    assign op_fail_map    = op_fail_map_q;
    assign first_fail_vld = first_fail_vld_q;
    assign first_fail_vec = first_fail_vec_q;
endmodule

// File: tb/tb_alu_mutation_scan_ctrl.sv
// tb_alu_mutation_scan_ctrl: directed scans against a golden ALU and an ADD/SUB sign-bit mutant
module tb_alu_mutation_scan_ctrl;
    typedef struct {
        int busy;
        int vc;
        int mc;
        int map;
        int vld;
        int vec;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1, start = 1'b0, abort = 1'b0, stop_on_fail = 1'b0;
    logic [7:0]  op_mask = '0;
    logic [3:0]  alu_a, alu_b, gold_result, mut_result;
    logic [2:0]  alu_opcode;
    logic        gold_zero, mut_zero, busy, done, first_fail_vld;
    logic [11:0] mismatch_cnt, vec_cnt;
    logic [7:0]  op_fail_map;
    logic [10:0] first_fail_vec;
    logic        mut_on = 1'b0;
    int          checks = 0, failures = 0;
    exp_t        sb[$];
    always #5 clk = ~clk;
    alu_mutation_scan_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .stop_on_fail(stop_on_fail),
        .op_mask(op_mask), .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .gold_result(gold_result), .gold_zero(gold_zero), .mut_result(mut_result),
        .mut_zero(mut_zero), .busy(busy), .done(done), .mismatch_cnt(mismatch_cnt),
        .vec_cnt(vec_cnt), .op_fail_map(op_fail_map), .first_fail_vld(first_fail_vld),
        .first_fail_vec(first_fail_vec)
    );
    function automatic logic [3:0] alu(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            3'd0: alu = a + b;
            3'd1: alu = a - b;
            3'd2: alu = a & b;
            3'd3: alu = a | b;
            3'd4: alu = a ^ b;
            3'd5: alu = a << b[1:0];
            3'd6: alu = a >> b[1:0];
            default: alu = 4'h0;
        endcase
    endfunction
    always_comb begin
        gold_result = alu(alu_opcode, alu_a, alu_b);
        gold_zero   = gold_result == 4'h0;
        mut_result  = (mut_on && alu_opcode <= 3'd1) ? gold_result ^ 4'h8 : gold_result;
        mut_zero    = mut_result == 4'h0;
    end
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic scan(input string tag, input logic [7:0] mask, input logic stop,
                        input int abort_at, input int start_at, input exp_t e);
        logic [2:0] eop;
        logic [7:0] eab;
        logic       found;
        int         n;
        exp_t       r;
        sb.push_back(e);
        op_mask = mask;
        stop_on_fail = stop;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op_mask = 8'h55;
        stop_on_fail = ~stop;
        eop = 3'd0;
        found = 1'b0;
        for (int i = 0; i < 8; i++) if (mask[i] && !found) begin eop = 3'(i); found = 1'b1; end
        eab = 8'h00;
        n = 0;
        while (busy && n < 5000) begin
            check({tag, " vec"}, {21'd0, alu_opcode, alu_a, alu_b}, {21'd0, eop, eab});
            n++;
            if (n == abort_at) abort = 1'b1;
            if (n == start_at) start = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            start = 1'b0;
            eab = eab + 8'd1;
            if (eab == 8'h00) begin
                found = 1'b0;
                for (int i = 0; i < 8; i++) if (mask[i] && i > int'(eop) && !found) begin eop = 3'(i); found = 1'b1; end
            end
        end
        r = sb.pop_front();
        check({tag, " busy_cycles"}, n, r.busy);
        check({tag, " done"}, {31'd0, done}, 1);
        check({tag, " vec_cnt"}, {20'd0, vec_cnt}, r.vc);
        check({tag, " mismatch_cnt"}, {20'd0, mismatch_cnt}, r.mc);
        check({tag, " op_fail_map"}, {24'd0, op_fail_map}, r.map);
        check({tag, " first_fail_vld"}, {31'd0, first_fail_vld}, r.vld);
        check({tag, " first_fail_vec"}, {21'd0, first_fail_vec}, r.vec);
    endtask
    task automatic check_idle(input string tag);
        check({tag, " busy"}, {31'd0, busy}, 0);
        check({tag, " done"}, {31'd0, done}, 0);
        check({tag, " alu"}, {21'd0, alu_opcode, alu_a, alu_b}, 0);
        check({tag, " counts"}, {8'd0, vec_cnt, mismatch_cnt}, 0);
        check({tag, " map"}, {24'd0, op_fail_map}, 0);
        check({tag, " first_fail"}, {20'd0, first_fail_vld, first_fail_vec}, 0);
    endtask
    initial begin
        @(negedge clk);
        @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        @(negedge clk);
        check_idle("idle");
        scan("golden_all", 8'hFF, 1'b0, 0, 0, '{busy: 2048, vc: 2048, mc: 0, map: 0, vld: 0, vec: 0});
        check("golden_all hold_last", {21'd0, alu_opcode, alu_a, alu_b}, 32'h7FF);
        @(negedge clk);
        check("golden_all done_stays", {31'd0, done}, 1);
        mut_on = 1'b1;
        scan("mutant_all", 8'hFF, 1'b0, 0, 0, '{busy: 2048, vc: 2048, mc: 512, map: 8'h03, vld: 1, vec: 0});
        scan("mutant_FC", 8'hFC, 1'b0, 0, 100, '{busy: 1536, vc: 1536, mc: 0, map: 0, vld: 0, vec: 0});
        scan("stop_on_fail", 8'hFF, 1'b1, 0, 0, '{busy: 1, vc: 1, mc: 1, map: 8'h01, vld: 1, vec: 0});
        scan("abort10", 8'hFF, 1'b0, 10, 0, '{busy: 10, vc: 9, mc: 9, map: 8'h01, vld: 1, vec: 0});
        scan("mask_zero", 8'h00, 1'b0, 0, 0, '{busy: 0, vc: 0, mc: 0, map: 0, vld: 0, vec: 0});
        scan("stop_late", 8'h0A, 1'b1, 0, 0, '{busy: 1, vc: 1, mc: 1, map: 8'h02, vld: 1, vec: 11'h100});
        op_mask = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        check("rst_mid busy", {31'd0, busy}, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle("rst_mid");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_idle done", {31'd0, done}, 0);
        mut_on = 1'b0;
        scan("after_rst", 8'h80, 1'b0, 0, 0, '{busy: 256, vc: 256, mc: 0, map: 0, vld: 0, vec: 0});
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
